// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, line/frame total helpers and RGB444 colour type
package vga_pkg;
    localparam int CNT_W        = 11;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIX_DIV_DEF  = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t BG_COLOR = 12'hffd;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_scanner_if.sv
// vga_scanner_if: renderer coordinate/colour bus, VGA pins and CPU status/irq lines of the scanner
interface vga_scanner_if;
    import vga_pkg::*;
    logic [CNT_W-1:0] vga_haddr;
    logic [CNT_W-1:0] vga_vaddr;
    rgb444_t          vga_data;
    logic             hs;
    logic             vs;
    logic [3:0]       r;
    logic [3:0]       g;
    logic [3:0]       b;
    logic             frame_start;
    logic             in_vblank;
    logic             irq;
    logic             irq_ack;

    modport master (
        output vga_haddr, vga_vaddr, hs, vs, r, g, b, frame_start, in_vblank, irq,
        input  vga_data, irq_ack
    );

    modport slave (
        input  vga_haddr, vga_vaddr, hs, vs, r, g, b, frame_start, in_vblank, irq,
        output vga_data, irq_ack
    );
endinterface

// File: rtl/vga_tick_gen.sv
// vga_tick_gen: pixel-rate enable, high on the last system clock of every PIX_DIV-clock period
module vga_tick_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div;

    assign tick = div == DW'(PIX_DIV - 1);

    // divider counts 0..PIX_DIV-1 and restarts after the tick clock
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) div <= '0;
        else       div <= tick ? '0 : div + DW'(1);
    end
endmodule

// File: rtl/vga_scanner.sv
// vga_scanner: VGA raster timing, renderer addressing, registered 4:4:4 output and vblank status.
// Optional vblank interrupt flop is built only when VGA_VBLANK_IRQ_EN is defined.
module vga_scanner
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_DIV  = PIX_DIV_DEF
) (
    input logic          clk,
    input logic          rstn,
    vga_scanner_if.master bus
);
    localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (HT >= 2048 || VT >= 2048 || PIX_DIV < 1) begin : g_illegal
        $error("vga_scanner: totals must be < 2048 and PIX_DIV >= 1");
    end

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_raw;
    logic             vs_raw;
    logic             active;

    vga_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    assign h_wrap = h_cnt == CNT_W'(HT - 1);
    assign v_wrap = v_cnt == CNT_W'(VT - 1);
    assign h_nxt  = !tick ? h_cnt : h_wrap ? '0 : h_cnt + CNT_W'(1);
    assign v_nxt  = !(tick && h_wrap) ? v_cnt : v_wrap ? '0 : v_cnt + CNT_W'(1);
    assign hs_raw = !(h_cnt >= CNT_W'(H_ACTIVE + H_FP) && h_cnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw = !(v_cnt >= CNT_W'(V_ACTIVE + V_FP) && v_cnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign active = h_cnt < CNT_W'(H_ACTIVE) && v_cnt < CNT_W'(V_ACTIVE);

    assign bus.vga_haddr = h_cnt;
    assign bus.vga_vaddr = v_cnt;

    // raster counters plus status flags derived from the counters' next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.in_vblank   <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            bus.in_vblank   <= v_nxt >= CNT_W'(V_ACTIVE);
            bus.frame_start <= tick && h_wrap && v_wrap;
        end
    end

    // one-pixel output stage keeps colour and syncs aligned on the pins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {bus.r, bus.g, bus.b} <= '0;
            bus.hs                <= 1'b1;
            bus.vs                <= 1'b1;
        end else if (tick) begin
            {bus.r, bus.g, bus.b} <= active ? bus.vga_data : rgb444_t'('0);
            bus.hs                <= hs_raw;
            bus.vs                <= vs_raw;
        end
    end

`ifdef VGA_VBLANK_IRQ_EN
    logic irq_set;

    assign irq_set = tick && h_wrap && v_cnt == CNT_W'(V_ACTIVE - 1);

    // sticky vblank interrupt; a set in the same clock as an ack wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bus.irq <= 1'b0;
        else       bus.irq <= irq_set || (bus.irq && !bus.irq_ack);
    end
`else
    logic unused_irq_ack;

    assign unused_irq_ack = bus.irq_ack;
    assign bus.irq        = 1'b0;
`endif
endmodule

// File: tb/tb_vga_scanner.sv
// tb_vga_scanner: scoreboard bench on a reduced raster (56x27 total, 4 clks/pixel)
module tb_vga_scanner;
    localparam int K_H = 0, K_V = 1, K_HS = 2, K_VS = 3, K_RGB = 4, K_FS = 5, K_VB = 6, K_IRQ = 7;
`ifdef VGA_VBLANK_IRQ_EN
    localparam logic [11:0] IRQ_ON = 12'd1;
`else
    localparam logic [11:0] IRQ_ON = 12'd0;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    bit          flush_req = 1'b0;
    bit          flushed = 1'b0;
    logic [11:0] got;
    exp_t        sb[$];

    vga_scanner_if bus();

    vga_scanner #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_DIV(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    assign bus.vga_data = {bus.vga_haddr[3:0], bus.vga_vaddr[3:0], 4'h5};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [11:0] sample(input int k);
        case (k)
            K_H:     return {1'b0, bus.vga_haddr};
            K_V:     return {1'b0, bus.vga_vaddr};
            K_HS:    return {11'd0, bus.hs};
            K_VS:    return {11'd0, bus.vs};
            K_RGB:   return {bus.r, bus.g, bus.b};
            K_FS:    return {11'd0, bus.frame_start};
            K_VB:    return {11'd0, bus.in_vblank};
            default: return {11'd0, bus.irq};
        endcase
    endfunction

    task automatic chk(input int c, input int k, input logic [11:0] e, input string n);
        exp_t x;
        x.cyc = c; x.kind = k; x.exp = e; x.name = n;
        sb.push_back(x);
    endtask

    task automatic at_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_reset_state(input string tag);
        chk(0, K_H,   12'd0, {tag, "_haddr"});
        chk(0, K_V,   12'd0, {tag, "_vaddr"});
        chk(0, K_HS,  12'd1, {tag, "_hs"});
        chk(0, K_VS,  12'd1, {tag, "_vs"});
        chk(0, K_RGB, 12'd0, {tag, "_rgb"});
        chk(0, K_FS,  12'd0, {tag, "_frame_start"});
        chk(0, K_VB,  12'd0, {tag, "_in_vblank"});
        chk(0, K_IRQ, 12'd0, {tag, "_irq"});
    endtask

    task automatic push_release(input string tag);
        chk(3,   K_H,   12'd0,     {tag, "_haddr_c3"});
        chk(4,   K_H,   12'd1,     {tag, "_haddr_c4"});
        chk(179, K_HS,  12'd1,     {tag, "_hs_pre_fall"});
        chk(180, K_HS,  12'd0,     {tag, "_hs_fall"});
        chk(203, K_HS,  12'd0,     {tag, "_hs_last_low"});
        chk(204, K_HS,  12'd1,     {tag, "_hs_rise"});
        chk(465, K_RGB, 12'h325,   {tag, "_rgb_3_2"});
    endtask

    // scoreboard monitor: compares every queued expectation on its cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = sample(sb[i].kind);
                checks++;
                if (got !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (flush_req && !flushed) begin
            foreach (sb[i]) begin
                checks++;
                errors++;
                $display("FAIL %s never sampled (cyc=%0d)", sb[i].name, sb[i].cyc);
            end
            sb.delete();
            flushed = 1'b1;
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_ack = 1'b0;
        push_reset_state("reset");
        repeat (10) @(posedge clk);
        #2 rstn = 1'b1;
        push_release("rel");
        chk(403,   K_HS,  12'd1,   "hs_line2_pre");
        chk(404,   K_HS,  12'd0,   "hs_line2_fall");
        chk(2836,  K_H,   12'd37,  "haddr_37");
        chk(2836,  K_V,   12'd12,  "vaddr_12");
        chk(2841,  K_RGB, 12'h5C5, "rgb_37_12");
        chk(2873,  K_RGB, 12'h000, "rgb_hblank");
        chk(4417,  K_RGB, 12'h735, "rgb_39_19");
        chk(4485,  K_RGB, 12'h000, "rgb_vblank");
        chk(4479,  K_VB,  12'd0,   "vblank_pre");
        chk(4479,  K_V,   12'd19,  "vaddr_19");
        chk(4480,  K_VB,  12'd1,   "vblank_rise");
        chk(4480,  K_V,   12'd20,  "vaddr_20");
        chk(4931,  K_VS,  12'd1,   "vs_pre_fall");
        chk(4932,  K_VS,  12'd0,   "vs_fall");
        chk(5379,  K_VS,  12'd0,   "vs_last_low");
        chk(5380,  K_VS,  12'd1,   "vs_rise");
        chk(6047,  K_H,   12'd55,  "haddr_last");
        chk(6047,  K_V,   12'd26,  "vaddr_last");
        chk(6047,  K_VB,  12'd1,   "vblank_last");
        chk(6047,  K_FS,  12'd0,   "fs_pre");
        chk(6048,  K_H,   12'd0,   "haddr_wrap");
        chk(6048,  K_V,   12'd0,   "vaddr_wrap");
        chk(6048,  K_VB,  12'd0,   "vblank_fall");
        chk(6048,  K_FS,  12'd1,   "fs_pulse1");
        chk(6049,  K_FS,  12'd0,   "fs_width1");
        chk(12095, K_FS,  12'd0,   "fs_pre2");
        chk(12096, K_FS,  12'd1,   "fs_pulse2");
        chk(12097, K_FS,  12'd0,   "fs_width2");
        chk(4479,  K_IRQ, 12'd0,   "irq_pre");
        chk(4480,  K_IRQ, IRQ_ON,  "irq_set");
        chk(10000, K_IRQ, IRQ_ON,  "irq_hold_f1");
        chk(16000, K_IRQ, IRQ_ON,  "irq_hold_f2");
        chk(22000, K_IRQ, IRQ_ON,  "irq_hold_f3");
        chk(22100, K_IRQ, IRQ_ON,  "irq_ack_clk");
        chk(22101, K_IRQ, 12'd0,   "irq_cleared");
        chk(22623, K_IRQ, 12'd0,   "irq_still_clear");
        chk(22624, K_IRQ, IRQ_ON,  "irq_set_beats_ack");
        chk(22625, K_IRQ, IRQ_ON,  "irq_after_race");
        at_cyc(22100);
        bus.irq_ack = 1'b1;
        at_cyc(22101);
        bus.irq_ack = 1'b0;
        at_cyc(22623);
        bus.irq_ack = 1'b1;
        at_cyc(22624);
        bus.irq_ack = 1'b0;
        at_cyc(26552);
        chk(26552, K_H, 12'd30, "mid_haddr_30");
        chk(26552, K_V, 12'd10, "mid_vaddr_10");
        at_cyc(26553);
        rstn = 1'b0;
        push_reset_state("midrst");
        repeat (10) @(posedge clk);
        #2 rstn = 1'b1;
        push_release("rel2");
        at_cyc(470);
        flush_req = 1'b1;
        while (!flushed) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
